semaforo_ctrl: RTL and testbench



---
 rtl/semaforo_pkg.sv | 42 ++++
 rtl/semaforo_ctrl_if.sv | 20 ++
 rtl/semaforo_ctrl_phase_timer.sv | 33 +++
 rtl/semaforo_ctrl.sv | 83 ++++++++
 tb/tb_semaforo_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and constants for the two-way traffic-light controller.
package semaforo_pkg;

    typedef enum logic [1:0] {
        AG,
        AY,
        BG,
        BY
    } state_e;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam int unsigned DEF_GREEN_CYC  = 0;
    localparam int unsigned DEF_YELLOW_CYC = 3;
    localparam int unsigned DEF_RED_CYC    = 2;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Last cnt value seen in a phase lasting max(cyc,1) cycles.
    function automatic logic [7:0] dwell_limit(input int unsigned cyc);
        logic [7:0] c;
        c = cyc[7:0];
        return (c == 8'd0) ? 8'd0 : c - 8'd1;
    endfunction

    // Lamp pair {A, B} shown in each state.
    function automatic logic [5:0] state_lamps(input state_e s);
        logic [5:0] l;
        l = {LAMP_GREEN, LAMP_RED};
        case (s)
            AG:      l = {LAMP_GREEN, LAMP_RED};
            AY:      l = {LAMP_YELLOW, LAMP_RED};
            BG:      l = {LAMP_RED, LAMP_GREEN};
            BY:      l = {LAMP_RED, LAMP_YELLOW};
            default: l = {LAMP_GREEN, LAMP_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_ctrl_if.sv
// Request button and lamp outputs of the traffic-light controller.
interface semaforo_ctrl_if;

    logic       bt;
    logic [2:0] A;
    logic [2:0] B;

    modport master (
        output bt,
        input  A,
        input  B
    );

    modport slave (
        input  bt,
        output A,
        output B
    );

endinterface

// File: rtl/semaforo_ctrl_phase_timer.sv
// Saturating 8-bit phase counter with clear and terminal-count compare.
module semaforo_ctrl_phase_timer
    import semaforo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic [7:0] limit_i,
    output logic       tc_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q >= limit_i);

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-way traffic-light controller: A rests green, a request runs A yellow, B green, B yellow.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned GREEN_CYC  = DEF_GREEN_CYC,
    parameter int unsigned YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int unsigned RED_CYC    = DEF_RED_CYC
) (
    input  logic            clk,
    input  logic            rst,
    semaforo_ctrl_if.slave  bus_io
);

    localparam logic [7:0] GreenLim  = GREEN_CYC[7:0];
    localparam logic [7:0] YellowLim = dwell_limit(YELLOW_CYC);
    localparam logic [7:0] RedLim    = dwell_limit(RED_CYC);

    state_e     state_q, state_d;
    logic       req_q, req_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [7:0] limit;
    logic       tc;
    logic       phase_change;

    always_comb begin
        limit = GreenLim;
        case (state_q)
            AG:      limit = GreenLim;
            AY, BY:  limit = YellowLim;
            BG:      limit = RedLim;
            default: limit = GreenLim;
        endcase
    end

    semaforo_ctrl_phase_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (phase_change),
        .limit_i (limit),
        .tc_o    (tc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            AG: begin
                if ((req_q || bus_io.bt) && tc) begin
                    state_d = AY;
                    req_d   = 1'b0;
                end else if (bus_io.bt) begin
                    req_d = 1'b1;
                end
            end
            AY:      if (tc) state_d = BG;
            BG:      if (tc) state_d = BY;
            BY:      if (tc) state_d = AG;
            default: state_d = AG;
        endcase
        phase_change = (state_d != state_q);
        // Lamps are registered from the next state so they change on the same edge.
        {a_d, b_d} = state_lamps(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AG;
            req_q   <= 1'b0;
            a_q     <= LAMP_GREEN;
            b_q     <= LAMP_RED;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus_io.A = a_q;
    assign bus_io.B = b_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench: three controllers with different timings against a phase-position model.
module tb_semaforo_ctrl;

    localparam logic [5:0] P_AG = 6'b001100;
    localparam logic [5:0] P_AY = 6'b010100;
    localparam logic [5:0] P_BG = 6'b100001;
    localparam logic [5:0] P_BY = 6'b100010;

    logic clk = 1'b0;
    logic rst;

    semaforo_ctrl_if if0 ();
    semaforo_ctrl_if if1 ();
    semaforo_ctrl_if if2 ();

    semaforo_ctrl #(.GREEN_CYC(0), .YELLOW_CYC(3), .RED_CYC(2)) dut0 (
        .clk(clk), .rst(rst), .bus_io(if0.slave)
    );
    semaforo_ctrl #(.GREEN_CYC(4), .YELLOW_CYC(3), .RED_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .bus_io(if1.slave)
    );
    semaforo_ctrl #(.GREEN_CYC(0), .YELLOW_CYC(0), .RED_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .bus_io(if2.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: green minimum, effective yellow/red lengths, and per-controller progress.
    int         m_g    [3] = '{0, 4, 0};
    int         m_y    [3] = '{3, 3, 1};
    int         m_r    [3] = '{2, 2, 1};
    bit         m_busy [3];
    int         m_pos  [3];
    bit         m_pend [3];
    int         m_age  [3];
    logic [5:0] m_exp  [3];

    function automatic logic bt_of(input int i);
        case (i)
            0:       return if0.bt;
            1:       return if1.bt;
            default: return if2.bt;
        endcase
    endfunction

    function automatic logic [5:0] dut_of(input int i);
        case (i)
            0:       return {if0.A, if0.B};
            1:       return {if1.A, if1.B};
            default: return {if2.A, if2.B};
        endcase
    endfunction

    function automatic logic [5:0] seq_pair(input int i, input int pos);
        if (pos < m_y[i]) return P_AY;
        if (pos < m_y[i] + m_r[i]) return P_BG;
        return P_BY;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t: got A=%b B=%b, required A=%b B=%b",
                     name, $time, act[5:3], act[2:0], req[5:3], req[2:0]);
        end
    endtask

    task automatic model_step(input int i);
        if (rst) begin
            m_busy[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_age[i]  = 0;
            m_exp[i]  = P_AG;
        end else if (m_busy[i]) begin
            m_pos[i]++;
            if (m_pos[i] >= 2 * m_y[i] + m_r[i]) begin
                m_busy[i] = 1'b0;
                m_age[i]  = 0;
                m_exp[i]  = P_AG;
            end else begin
                m_exp[i] = seq_pair(i, m_pos[i]);
            end
        end else if ((m_pend[i] || bt_of(i)) && m_age[i] >= m_g[i]) begin
            m_busy[i] = 1'b1;
            m_pend[i] = 1'b0;
            m_pos[i]  = 0;
            m_exp[i]  = seq_pair(i, 0);
        end else begin
            m_pend[i] = m_pend[i] | bt_of(i);
            if (m_age[i] < 255) m_age[i]++;
            m_exp[i] = P_AG;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0;
            m_pos[i]  = 0;
            m_pend[i] = 1'b0;
            m_age[i]  = 0;
            m_exp[i]  = P_AG;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check($sformatf("model_dut%0d", i), dut_of(i), m_exp[i]);
        end
    end

    // Expected lamps after directed edges 1..14 following a reset release.
    logic [5:0] exp0 [14] = '{P_AY, P_AY, P_AY, P_BG, P_BG, P_BY, P_BY, P_BY,
                              P_AG, P_AG, P_AG, P_AG, P_AG, P_AG};
    logic [5:0] exp1 [14] = '{P_AG, P_AG, P_AG, P_AG, P_AY, P_AY, P_AY, P_BG,
                              P_BG, P_BY, P_BY, P_BY, P_AG, P_AG};
    logic [5:0] exp2 [14] = '{P_AY, P_BG, P_BY, P_AG, P_AG, P_AG, P_AG, P_AG,
                              P_AG, P_AG, P_AG, P_AG, P_AG, P_AG};

    initial begin
        rst    = 1'b1;
        if0.bt = 1'b0;
        if1.bt = 1'b0;
        if2.bt = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_pre_edge_dut%0d", i), dut_of(i), P_AG);

        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("idle20_dut%0d", i), dut_of(i), P_AG);

        // Directed: single press at edge 1 after reset; dut0 also pressed during BG.
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        if0.bt = 1'b1;
        if1.bt = 1'b1;
        if2.bt = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            if0.bt = (e == 4);
            if1.bt = 1'b0;
            if2.bt = 1'b0;
            check($sformatf("seq_dut0_e%0d", e), dut_of(0), exp0[e-1]);
            check($sformatf("seq_dut1_e%0d", e), dut_of(1), exp1[e-1]);
            check($sformatf("seq_dut2_e%0d", e), dut_of(2), exp2[e-1]);
        end

        // Asynchronous reset between edges while dut0 is in yellow.
        if0.bt = 1'b1;
        @(posedge clk);
        #2;
        check("ay_before_async_rst", dut_of(0), P_AY);
        rst    = 1'b1;
        if0.bt = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("async_rst_dut%0d", i), dut_of(i), P_AG);
        @(negedge clk);
        rst    = 1'b0;
        if1.bt = 1'b1;
        @(negedge clk);
        if1.bt = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("req_cleared_by_rst", dut_of(1), P_AG);

        // Randomized presses with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            if0.bt = ($urandom_range(0, 7) == 0);
            if1.bt = ($urandom_range(0, 7) == 0);
            if2.bt = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 299) == 0);
        end

        @(negedge clk);
        rst    = 1'b0;
        if0.bt = 1'b0;
        if1.bt = 1'b0;
        if2.bt = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("final_rest_dut%0d", i), dut_of(i), P_AG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
